cpu_fetch: RTL

- Front-end fetch stage that feeds the `cpu_fsm` decode/execute stage.
- Reads instruction bytes one per cycle from a byte-wide synchronous memory into a circular byte buffer.
- Presents a 4-byte bundle (opcode plus three operand bytes) to the executer through a valid/ready handshake; the executer pops 1–4 bytes per instruction.
- Handles redirects (jumps) by flushing, and stops fetching while the executer is halted.

---
 rtl/cpu_fetch.sv | 115 +++++++++++
 1 files changed

// File: rtl/cpu_fetch.sv
// Fetch front end: streams bytes from a byte-wide synchronous memory into a
// circular buffer and presents a 4-byte bundle to the executer.
module cpu_fetch #(
  parameter logic [15:0] RESET_PC = 16'h8000,
  parameter int          DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        f_valid,
  output logic [7:0]  f_insn,
  output logic [7:0]  f_q1,
  output logic [7:0]  f_q2,
  output logic [7:0]  f_q3,
  output logic [15:0] f_pc,
  input  logic        f_ready,
  input  logic [1:0]  f_len,
  input  logic        redir,
  input  logic [15:0] redir_pc,
  input  logic        halt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [15:0]           fetch_pc_q, fetch_pc_d;
  logic [15:0]           f_pc_q, f_pc_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [DEPTH-1:0][7:0] buf_q, buf_d;
  logic [3:0][7:0]       bundle;
  logic                  issue, capture, pop;
  logic [2:0]            pop_n;

  // Issue check ignores a same-cycle pop so it never depends on f_ready.
  assign issue   = rst & ~halt & ~redir & ((count_q + CW'(inflight_q)) < DEPTH_C);
  assign capture = inflight_q & ~redir;
  assign f_valid = rst & (count_q >= CW'(4));
  assign pop     = f_valid & f_ready & ~redir;
  assign pop_n   = {1'b0, f_len} + 3'd1;

  assign mem_rd   = issue;
  assign mem_addr = fetch_pc_q;

  for (genvar k = 0; k < 4; k++) begin : g_tap
    logic [PW-1:0] idx;
    assign idx       = head_q + PW'(k);
    assign bundle[k] = buf_q[idx];
  end

  assign f_insn = bundle[0];
  assign f_q1   = bundle[1];
  assign f_q2   = bundle[2];
  assign f_q3   = bundle[3];
  assign f_pc   = f_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    f_pc_d     = f_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    buf_d      = buf_q;
    if (redir) begin
      // Flush: any byte returning this cycle is dropped with the rest.
      fetch_pc_d = redir_pc;
      f_pc_d     = redir_pc;
      head_d     = tail_q;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) fetch_pc_d = fetch_pc_q + 16'd1;
      if (capture) begin
        buf_d[tail_q] = mem_rdata;
        tail_d        = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(pop_n);
        f_pc_d = f_pc_q + 16'(pop_n);
      end
      count_d = count_q + CW'(capture) - (pop ? CW'(pop_n) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      f_pc_q     <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      f_pc_q     <= f_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Buffer contents are only meaningful below count, so they carry no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule
